sc_seg7_scan: RTL and testbench



---
 rtl/sc_seg7_scan_if.sv | 21 ++
 rtl/sc_seg7_scan.sv | 128 ++++++++++++
 tb/tb_sc_seg7_scan.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sc_seg7_scan_if.sv
// Display-side bundle for sc_seg7_scan: CPU output word and controls in,
// active-low anode/segment/dp lines and frame pulse out.
interface sc_seg7_scan_if;
    logic [31:0] out_port;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output out_port, dp_mask, blank_lz,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  out_port, dp_mask, blank_lz,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/sc_seg7_scan.sv
// Eight-digit multiplexed seven-segment driver: per-frame snapshot of the CPU
// output word, one hex nibble per slot, inter-digit blanking, optional LZ suppression.
module sc_seg7_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 16
) (
    input  logic          clock,
    input  logic          clr,
    sc_seg7_scan_if.slave bus
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]    digit_q, digit_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    dp_snap_q, dp_snap_d;
    logic          lz_snap_q, lz_snap_d;
    logic          load_pend_q, load_pend_d;

    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          frame_wrap;
    logic          in_blank;
    logic [7:0]    lz_dark;
    logic [3:0]    nib;
    logic          dark;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end   = (div_cnt_q == DIV_MAX);
    assign frame_wrap = slot_end && (digit_q == 3'd7);

    // With no blanking the compare would be constant-false, so drop it entirely.
    if (BLANK == 0) begin : g_no_blank
        assign in_blank = 1'b0;
    end else begin : g_blank
        localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
        assign in_blank = (div_cnt_q < BLANK_C);
    end

    // Digit i goes dark under suppression when every nibble from i upward is zero.
    always_comb begin
        lz_dark = '0;
        for (int i = 1; i < 8; i++) begin
            lz_dark[i] = ((snap_q >> (4 * i)) == 32'd0);
        end
    end

    assign nib  = snap_q[{digit_q, 2'b00} +: 4];
    assign dark = in_blank || (lz_snap_q && lz_dark[digit_q]);

    // NOTE: every comb-assigned signal gets a default first so no latch can be inferred.
    always_comb begin
        div_cnt_d   = slot_end ? '0 : div_cnt_q + 1'b1;
        digit_d     = slot_end ? digit_q + 3'd1 : digit_q;
        snap_d      = snap_q;
        dp_snap_d   = dp_snap_q;
        lz_snap_d   = lz_snap_q;
        load_pend_d = load_pend_q;
        if (load_pend_q || frame_wrap) begin
            snap_d      = bus.out_port;
            dp_snap_d   = bus.dp_mask;
            lz_snap_d   = bus.blank_lz;
            load_pend_d = 1'b0;
        end
    end

    // Outputs are registered from the pre-edge counter/snapshot, hence one cycle of lag.
    always_comb begin
        an_d         = 8'hFF;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = frame_wrap;
        if (!dark) begin
            an_d  = ~(8'h01 << digit_q);
            seg_d = seg_decode(nib);
            dp_d  = ~dp_snap_q[digit_q];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (clr) begin
            div_cnt_q    <= '0;
            digit_q      <= '0;
            snap_q       <= '0;
            dp_snap_q    <= '0;
            lz_snap_q    <= 1'b0;
            load_pend_q  <= 1'b1;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_q      <= digit_d;
            snap_q       <= snap_d;
            dp_snap_q    <= dp_snap_d;
            lz_snap_q    <= lz_snap_d;
            load_pend_q  <= load_pend_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sc_seg7_scan.sv
// Directed bench for sc_seg7_scan with SCAN_DIV=4, BLANK=1: table of per-digit
// expectations checked cycle by cycle over two frames, plus tearing and mid-frame reset.
module tb_sc_seg7_scan;

    localparam int SCAN_DIV = 4;
    localparam int BLANK    = 1;
    localparam int FRAME    = 8 * SCAN_DIV;

    logic clock = 1'b0;
    logic clr   = 1'b1;
    always #5 clock = ~clock;

    sc_seg7_scan_if bus ();

    sc_seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0]     out_port;
        logic [7:0]      dp_mask;
        logic            lz;
        logic [7:0][6:0] seg;   // expected segments per digit, index = digit
        logic [7:0]      dark;  // digits expected dark by suppression
    } vec_t;

    localparam logic [7:0][7:0] AN_LIT = {8'h7F, 8'hBF, 8'hDF, 8'hEF,
                                          8'hF7, 8'hFB, 8'hFD, 8'hFE};
    localparam logic [16:0] DARK_OUT = {8'hFF, 7'h7F, 1'b1, 1'b0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h dp=%b fd=%b",
                     name, act[16:9], act[8:2], act[1], act[0],
                     exp[16:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    function automatic logic [16:0] sample();
        return {bus.an, bus.seg, bus.dp, bus.frame_done};
    endfunction

    task automatic apply(input vec_t v);
        bus.out_port = v.out_port;
        bus.dp_mask  = v.dp_mask;
        bus.blank_lz = v.lz;
    endtask

    // Hold clr for n edges with v's inputs presented, checking the dark reset state.
    task automatic do_reset(input vec_t v, input int n, input string tag);
        apply(v);
        clr = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("%s r%0d", tag, i), sample(), DARK_OUT);
        end
        clr = 1'b0;
    endtask

    // Cycle k is the k-th edge after reset release; output reflects pre-edge slot
    // phase (k-1)%4 of digit ((k-1)/4)%8. Frame 1 shows va, frame 2 shows vb.
    task automatic run_frames(input vec_t va, input vec_t vb, input int chg_k,
                              input int n, input string tag);
        vec_t        v;
        int          ph, d;
        logic [16:0] exp;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            @(negedge clock);
            v  = (k > FRAME) ? vb : va;
            ph = (k - 1) % SCAN_DIV;
            d  = ((k - 1) / SCAN_DIV) % 8;
            if (ph < BLANK || v.dark[d])
                exp = DARK_OUT;
            else
                exp = {AN_LIT[d], v.seg[d], ~v.dp_mask[d], 1'b0};
            exp[0] = (k % FRAME == 0);
            check($sformatf("%s k=%0d", tag, k), sample(), exp);
            if (k == chg_k) apply(vb);
        end
    endtask

    vec_t vecs[6];
    vec_t v_zero, v_ones, v_new;

    initial begin
        vecs[0] = '{32'h12345678, 8'h00, 1'b0,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'h00};
        vecs[1] = '{32'hFEDCBA98, 8'h00, 1'b0,
                    {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 8'h00};
        vecs[2] = '{32'h00000A05, 8'h00, 1'b1,
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12}, 8'hF8};
        vecs[3] = '{32'h00000000, 8'h00, 1'b1,
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'hFE};
        vecs[4] = '{32'h00000000, 8'h04, 1'b0,
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h00};
        vecs[5] = '{32'h80000000, 8'h00, 1'b1,
                    {7'h00, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h00};
        v_zero  = '{32'h00000000, 8'h00, 1'b0,
                    {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 8'h00};
        v_ones  = '{32'hFFFFFFFF, 8'h00, 1'b0,
                    {7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 7'h0E}, 8'h00};
        v_new   = '{32'h9ABCDEF0, 8'h00, 1'b0,
                    {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}, 8'h00};

        // Power-up: three reset cycles, then the table vectors over two frames each.
        do_reset(vecs[0], 3, "powerup");
        run_frames(vecs[0], vecs[0], 0, 2 * FRAME, "vec0");
        for (int i = 1; i < 6; i++) begin
            do_reset(vecs[i], 1, $sformatf("vec%0d_rst", i));
            run_frames(vecs[i], vecs[i], 0, 2 * FRAME, $sformatf("vec%0d", i));
        end

        // Anti-tearing: flip the word while digit 3 is lit (k=14).
        do_reset(v_zero, 1, "tear_rst");
        run_frames(v_zero, v_ones, 14, 2 * FRAME, "tear");

        // Mid-frame reset while digit 5 is lit (k=22), then restart with a new word.
        do_reset(vecs[0], 1, "mid_rst0");
        run_frames(vecs[0], vecs[0], 0, 22, "mid_pre");
        do_reset(v_new, 2, "mid_clr");
        run_frames(v_new, v_new, 0, 2 * FRAME, "mid_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
